i2s_tx_stream: RTL and testbench

// - Parametrised I2S transmitter for the codec unit. Accepts stereo samples on a valid/ready stream into an internal FIFO.
// - Divides clk down to generate i2s_bclk, and drives i2s_wclk and i2s_data MSB-first.
// - On FIFO starvation it sends silence and flags a sticky underflow.

---
 rtl/i2s_tx_stream.sv | 196 +++++++++++++++++++
 tb/tb_i2s_tx_stream.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_stream.sv
// I2S transmitter: stereo samples in through a valid/ready FIFO, serialised MSB-first on bclk/wclk/data.
// Latency: first bit is driven BCLK_DIV clks after enable rises; fifo_level follows a push/pop by one clk.
// Backpressure: s_ready drops while the FIFO is full. Define I2S_TX_LJ_EN for left-justified wclk timing.

module i2s_tx_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full_o     = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign level_o    = cnt_q;
    assign head_dat_o = mem_q[rd_q];

    // A full FIFO refuses a push even when it is popped in the same clk.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = push_ok ? wr_q + AW'(1) : wr_q;
        rd_d  = pop_ok  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= push_dat_i;
        end
    end
endmodule

module i2s_tx_stream #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCLK_DIV     = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [2*SAMPLE_WIDTH-1:0]     s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    input  logic                          underflow_clr,
    output logic                          frame_start,
    output logic                          i2s_bclk,
    output logic                          i2s_wclk,
    output logic                          i2s_data
);
    localparam int FRAME_W = 2*SLOT_WIDTH;
    localparam int PAD     = SLOT_WIDTH - SAMPLE_WIDTH;
    localparam int DIV_W   = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W   = $clog2(FRAME_W);

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(BCLK_DIV-1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV/2-1);
    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(FRAME_W-1);

    logic [DIV_W-1:0]            div_q, div_d;
    logic [BIT_W-1:0]            bit_q, bit_d, bit_nxt;
    logic                        bclk_q, bclk_d;
    logic                        wclk_q, wclk_d;
    logic [FRAME_W-1:0]          sh_q, sh_d;
    logic                        fs_q, fs_d;
    logic                        uf_q, uf_d;
    logic                        fall, load;
    logic                        fifo_full, fifo_empty;
    logic [2*SAMPLE_WIDTH-1:0]   head;
    logic [SLOT_WIDTH-1:0]       l_slot, r_slot;

    i2s_tx_fifo #(
        .W     (2*SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (s_valid),
        .push_dat_i (s_data),
        .pop_i      (load),
        .head_dat_o (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    function automatic logic wclk_for(input logic [BIT_W-1:0] b);
`ifdef I2S_TX_LJ_EN
        return int'(b) >= SLOT_WIDTH;
`else
        // Standard I2S: wclk switches one bclk ahead of each channel MSB.
        return (int'(b) >= SLOT_WIDTH-1) && (int'(b) <= FRAME_W-2);
`endif
    endfunction

    assign fall    = enable && (div_q == DIV_MAX);
    assign bit_nxt = (bit_q == BIT_MAX) ? '0 : bit_q + BIT_W'(1);
    assign load    = fall && (bit_nxt == '0);
    assign l_slot  = SLOT_WIDTH'(head[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH]) << PAD;
    assign r_slot  = SLOT_WIDTH'(head[SAMPLE_WIDTH-1:0]) << PAD;

    always_comb begin
        div_d  = div_q;
        bit_d  = bit_q;
        bclk_d = bclk_q;
        wclk_d = wclk_q;
        sh_d   = sh_q;
        fs_d   = 1'b0;
        uf_d   = uf_q;
        if (load && fifo_empty) begin
            uf_d = 1'b1;
        end else if (underflow_clr) begin
            uf_d = 1'b0;
        end
        if (!enable) begin
            div_d  = '0;
            bit_d  = BIT_MAX;
            bclk_d = 1'b0;
            wclk_d = 1'b0;
            sh_d   = '0;
        end else begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
            if (div_q == DIV_HALF) begin
                bclk_d = 1'b1;
            end
            if (fall) begin
                bclk_d = 1'b0;
                bit_d  = bit_nxt;
                wclk_d = wclk_for(bit_nxt);
                if (load) begin
                    sh_d = fifo_empty ? '0 : {l_slot, r_slot};
                    fs_d = 1'b1;
                end else begin
                    sh_d = sh_q << 1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            bit_q  <= BIT_MAX;
            bclk_q <= 1'b0;
            wclk_q <= 1'b0;
            sh_q   <= '0;
            fs_q   <= 1'b0;
            uf_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            bit_q  <= bit_d;
            bclk_q <= bclk_d;
            wclk_q <= wclk_d;
            sh_q   <= sh_d;
            fs_q   <= fs_d;
            uf_q   <= uf_d;
        end
    end

    assign s_ready     = ~fifo_full;
    assign underflow   = uf_q;
    assign frame_start = fs_q;
    assign i2s_bclk    = bclk_q;
    assign i2s_wclk    = wclk_q;
    assign i2s_data    = sh_q[FRAME_W-1];
endmodule

// File: tb/tb_i2s_tx_stream.sv
// Directed bench for i2s_tx_stream with default parameters (24-bit samples, 32-bit slots, BCLK_DIV=4, depth 4).
module tb_i2s_tx_stream;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [47:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [2:0]  fifo_level;
    logic        underflow;
    logic        underflow_clr;
    logic        frame_start;
    logic        i2s_bclk;
    logic        i2s_wclk;
    logic        i2s_data;

    int n_checks = 0;
    int n_errors = 0;

    i2s_tx_stream dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .fifo_level    (fifo_level),
        .underflow     (underflow),
        .underflow_clr (underflow_clr),
        .frame_start   (frame_start),
        .i2s_bclk      (i2s_bclk),
        .i2s_wclk      (i2s_wclk),
        .i2s_data      (i2s_data)
    );

    always #5 clk = ~clk;

`ifdef I2S_TX_LJ_EN
    localparam logic [63:0] WCLK_EXP = 64'h0000_0000_FFFF_FFFF;
`else
    localparam logic [63:0] WCLK_EXP = 64'h0000_0001_FFFF_FFFE;
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
        return {l, 8'h00, r, 8'h00};
    endfunction

    task automatic push(input logic [47:0] d);
        s_data  = d;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_fs(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!frame_start && cycles < 600);
        if (!frame_start) check_eq(tag, 64'd0, 64'd1);
    endtask

    // Samples data and wclk on each bclk rise, bit 0 landing in position 63.
    task automatic capture(input int nbits, output logic [63:0] d, output logic [63:0] w);
        logic pb;
        int   n;
        d = '0;
        w = '0;
        for (int i = 0; i < nbits; i++) begin
            n  = 0;
            pb = i2s_bclk;
            @(negedge clk);
            while (!(i2s_bclk && !pb) && n < 16) begin
                pb = i2s_bclk;
                @(negedge clk);
                n++;
            end
            if (n >= 16) check_eq("bclk_timeout", 64'd0, 64'd1);
            d[63-i] = i2s_data;
            w[63-i] = i2s_wclk;
        end
    endtask

    logic [63:0] cap_d, cap_w;
    logic [23:0] fl [5];
    logic [23:0] fr [5];
    int          cyc;
    logic        any_hi;

    initial begin
        reset = 1'b1; enable = 1'b0; s_data = '0; s_valid = 1'b0; underflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_outs", {58'd0, i2s_bclk, i2s_wclk, i2s_data, underflow, frame_start, s_ready}, 64'd1);
        check_eq("rst_level", 64'(fifo_level), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Empty FIFO: silent frame, underflow and frame_start after 4 clks.
        enable = 1'b1;
        wait_fs("fs1_timeout", cyc);
        check_eq("fs1_cycle", 64'(cyc), 64'd4);
        check_eq("uf1_set", 64'(underflow), 64'd1);
        underflow_clr = 1'b1;
        @(negedge clk);
        underflow_clr = 1'b0;
        check_eq("uf1_clr", 64'(underflow), 64'd0);
        repeat (254) @(negedge clk);
        underflow_clr = 1'b1;
        @(negedge clk);
        underflow_clr = 1'b0;
        check_eq("fs2_aligned", 64'(frame_start), 64'd1);
        check_eq("uf_set_wins", 64'(underflow), 64'd1);
        capture(64, cap_d, cap_w);
        check_eq("silence_data", cap_d, 64'd0);
        check_eq("silence_wclk", cap_w, WCLK_EXP);
        check_eq("uf_sticky", 64'(underflow), 64'd1);
        underflow_clr = 1'b1;
        @(negedge clk);
        underflow_clr = 1'b0;
        check_eq("uf_clr_alone", 64'(underflow), 64'd0);

        // Reset while running mid-frame with a frame buffered.
        push(48'h123456_654321);
        repeat (20) @(negedge clk);
        check_eq("lvl_before_rst", 64'(fifo_level), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_outs", {58'd0, i2s_bclk, i2s_wclk, i2s_data, underflow, frame_start, s_ready}, 64'd1);
        check_eq("midrst_level", 64'(fifo_level), 64'd0);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single known frame.
        push({24'hA5A5A5, 24'h5A5A5A});
        check_eq("lvl_one", 64'(fifo_level), 64'd1);
        enable = 1'b1;
        wait_fs("fs3_timeout", cyc);
        check_eq("fs3_cycle", 64'(cyc), 64'd4);
        check_eq("lvl_popped", 64'(fifo_level), 64'd0);
        check_eq("uf_none", 64'(underflow), 64'd0);
        capture(64, cap_d, cap_w);
        check_eq("a5_data", cap_d, frame_of(24'hA5A5A5, 24'h5A5A5A));
        check_eq("a5_wclk", cap_w, WCLK_EXP);
        enable = 1'b0;
        @(negedge clk);

        // Fill past capacity while idle.
        for (int k = 0; k < 5; k++) begin
            fl[k] = 24'h111111 * 24'(k + 1);
            fr[k] = ~fl[k];
        end
        s_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_data = {fl[k], fr[k]};
            @(negedge clk);
            check_eq($sformatf("fill_lvl%0d", k), 64'(fifo_level), 64'(k < 4 ? k + 1 : 4));
        end
        s_valid = 1'b0;
        check_eq("full_rdy", 64'(s_ready), 64'd0);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_fs($sformatf("fill_fs%0d_timeout", k), cyc);
            capture(64, cap_d, cap_w);
            check_eq($sformatf("fill_frame%0d", k), cap_d, frame_of(fl[k], fr[k]));
        end
        check_eq("uf_after4", 64'(underflow), 64'd0);
        wait_fs("fill_fs4_timeout", cyc);
        check_eq("fifth_dropped", 64'(underflow), 64'd1);
        enable = 1'b0;
        underflow_clr = 1'b1;
        @(negedge clk);
        underflow_clr = 1'b0;

        // Drop enable at bit 40, resume on the next entry.
        push({24'hC3C3C3, 24'h3C3C3C});
        push({24'h0F0F0F, 24'hF0F0F0});
        enable = 1'b1;
        wait_fs("fs5_timeout", cyc);
        capture(40, cap_d, cap_w);
        check_eq("partial_bits", {cap_d[63:24], 24'd0}, {frame_of(24'hC3C3C3, 24'h3C3C3C)} & 64'hFFFF_FFFF_FF00_0000);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        any_hi = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            any_hi = any_hi | i2s_bclk | i2s_wclk | i2s_data | frame_start;
        end
        check_eq("idle_held_low", 64'(any_hi), 64'd0);
        check_eq("idle_level", 64'(fifo_level), 64'd1);
        enable = 1'b1;
        wait_fs("fs6_timeout", cyc);
        check_eq("resume_cycle", 64'(cyc), 64'd4);
        capture(64, cap_d, cap_w);
        check_eq("resume_frame", cap_d, frame_of(24'h0F0F0F, 24'hF0F0F0));
        check_eq("resume_wclk", cap_w, WCLK_EXP);
        check_eq("resume_uf", 64'(underflow), 64'd0);
        enable = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
